fetch_queue: RTL and testbench

FETCH_QUEUE -- requirements
Module: fetch_queue

---
 rtl/fetch_queue.sv | 104 ++++++++++
 tb/tb_fetch_queue.sv | 193 +++++++++++++++++++
 2 files changed

// File: rtl/fetch_queue.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : fetch_queue                                                     |
// | Brief    : PC generator + imem issue + circular instruction queue with     |
// |            branch redirect flush, feeding a decode stage by handshake.     |
// | Revision : 1.0                                                             |
// +----------------------------------------------------------------------------+
module fetch_queue #(
  parameter int                ADDR_W   = 32,
  parameter int                INSN_W   = 32,
  parameter int                DEPTH    = 4,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic                       clock,
  input  logic                       reset,
  output logic [ADDR_W-1:0]          address_imem,
  input  logic [INSN_W-1:0]          q_imem,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [INSN_W-1:0]          out_insn,
  output logic [ADDR_W-1:0]          out_pc,
  output logic [ADDR_W-1:0]          out_pc_plus_one,
  input  logic                       redirect_valid,
  input  logic [ADDR_W-1:0]          redirect_pc,
  output logic [$clog2(DEPTH):0]     count
);

  localparam int                c_pw    = $clog2(DEPTH);
  localparam int                c_cw    = c_pw + 1;
  localparam logic [c_cw-1:0]   c_depth = c_cw'(DEPTH);

  logic [ADDR_W-1:0] r_pc;
  logic              r_infl;
  logic [ADDR_W-1:0] r_infl_pc;
  logic [INSN_W-1:0] r_mem_insn [DEPTH];
  logic [ADDR_W-1:0] r_mem_pc   [DEPTH];
  logic [c_pw-1:0]   r_wptr;
  logic [c_pw-1:0]   r_rptr;
  logic [c_cw-1:0]   r_count;

  logic [c_cw-1:0]   w_occ;
  logic              w_issue;
  logic              w_push;
  logic              w_pop;

  // Outstanding imem request reserves a slot, so the queue can never overflow.
  assign w_occ   = r_count + {{c_pw{1'b0}}, r_infl};
  assign w_issue = !redirect_valid && (w_occ < c_depth);
  assign w_push  = r_infl && !redirect_valid;
  assign w_pop   = (r_count != '0) && out_ready && !redirect_valid;

  always_ff @(posedge clock) begin
    if (reset) begin
      r_pc      <= RESET_PC;
      r_infl    <= 1'b0;
      r_infl_pc <= '0;
      r_wptr    <= '0;
      r_rptr    <= '0;
      r_count   <= '0;
    end else if (redirect_valid) begin
      r_pc      <= redirect_pc;
      r_infl    <= 1'b0;
      r_wptr    <= '0;
      r_rptr    <= '0;
      r_count   <= '0;
    end else begin
      if (w_issue) begin
        r_pc      <= r_pc + {{(ADDR_W-1){1'b0}}, 1'b1};
        r_infl    <= 1'b1;
        r_infl_pc <= r_pc;
      end else begin
        r_infl    <= 1'b0;
      end
      if (w_push) begin
        r_wptr <= r_wptr + c_pw'(1);
      end
      if (w_pop) begin
        r_rptr <= r_rptr + c_pw'(1);
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + c_cw'(1);
        2'b01:   r_count <= r_count - c_cw'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  // Storage needs no reset: occupancy alone decides what is valid.
  always_ff @(posedge clock) begin
    if (!reset && w_push) begin
      r_mem_insn[r_wptr] <= q_imem;
      r_mem_pc[r_wptr]   <= r_infl_pc;
    end
  end

  assign address_imem    = r_pc;
  assign out_valid       = (r_count != '0);
  assign out_insn        = r_mem_insn[r_rptr];
  assign out_pc          = r_mem_pc[r_rptr];
  assign out_pc_plus_one = out_pc + {{(ADDR_W-1){1'b0}}, 1'b1};
  assign count           = r_count;

endmodule
`default_nettype wire

// File: tb/tb_fetch_queue.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : tb_fetch_queue                                                  |
// | Brief    : Self-checking bench for fetch_queue against a queue-based model.|
// | Revision : 1.0                                                             |
// +----------------------------------------------------------------------------+
module tb_fetch_queue;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic [31:0] address_imem;
  logic [31:0] q_imem = '0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [31:0] out_insn;
  logic [31:0] out_pc;
  logic [31:0] out_pc_plus_one;
  logic        redirect_valid = 1'b0;
  logic [31:0] redirect_pc = '0;
  logic [2:0]  count;

  logic [7:0]  a8;
  logic [31:0] q8 = '0;
  logic        v8;
  logic [31:0] insn8;
  logic [7:0]  pc8;
  logic [7:0]  pp8;
  logic [2:0]  cnt8;

  int total = 0;
  int bad   = 0;

  logic [31:0] m_pc = '0;
  bit          m_infl = 1'b0;
  logic [31:0] m_infl_pc = '0;
  logic [31:0] m_q[$];
  int          m_hs = 0;
  int          obs_hs = 0;

  fetch_queue #(.ADDR_W(32), .INSN_W(32), .DEPTH(4), .RESET_PC(32'h0)) u_dut (
    .clock(clock), .reset(reset), .address_imem(address_imem), .q_imem(q_imem),
    .out_valid(out_valid), .out_ready(out_ready), .out_insn(out_insn),
    .out_pc(out_pc), .out_pc_plus_one(out_pc_plus_one),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc), .count(count)
  );

  fetch_queue #(.ADDR_W(8), .INSN_W(32), .DEPTH(4), .RESET_PC(8'h0)) u_dut8 (
    .clock(clock), .reset(reset), .address_imem(a8), .q_imem(q8),
    .out_valid(v8), .out_ready(out_ready), .out_insn(insn8),
    .out_pc(pc8), .out_pc_plus_one(pp8),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc[7:0]), .count(cnt8)
  );

  always #5 clock = ~clock;

  // imem: returns addr + 0x100 one cycle after the address is presented
  always @(posedge clock) begin
    q_imem <= address_imem + 32'h100;
    q8     <= {24'h0, a8} + 32'h100;
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_all();
    chk("count", {61'h0, count}, m_q.size());
    chk("out_valid", {63'h0, out_valid}, {63'h0, m_q.size() != 0});
    chk("address_imem", {32'h0, address_imem}, {32'h0, m_pc});
    chk("handshakes", obs_hs, m_hs);
    if (m_q.size() != 0) begin
      chk("out_pc", {32'h0, out_pc}, {32'h0, m_q[0]});
      chk("out_insn", {32'h0, out_insn}, {32'h0, m_q[0] + 32'h100});
      chk("out_pc_plus_one", {32'h0, out_pc_plus_one}, {32'h0, m_q[0] + 32'd1});
    end
  endtask

  // Advance the reference model by one clock using the inputs currently driven.
  task automatic step();
    bit iss;
    if (!reset && out_valid === 1'b1 && out_ready) obs_hs++;
    if (reset) begin
      m_pc = 32'h0; m_infl = 1'b0; m_q.delete();
    end else if (redirect_valid) begin
      if (m_q.size() != 0 && out_ready) m_hs++;
      m_pc = redirect_pc; m_infl = 1'b0; m_q.delete();
    end else begin
      iss = (m_q.size() + int'(m_infl)) < 4;
      if (m_q.size() != 0 && out_ready) begin
        m_hs++;
        void'(m_q.pop_front());
      end
      if (m_infl) m_q.push_back(m_infl_pc);
      if (iss) begin
        m_infl_pc = m_pc; m_pc = m_pc + 32'd1; m_infl = 1'b1;
      end else begin
        m_infl = 1'b0;
      end
    end
    @(posedge clock);
    #1;
    check_all();
  endtask

  task automatic fill_to_three();
    for (int i = 0; i < 20; i++) begin
      if (m_q.size() == 3 && m_infl) break;
      step();
    end
    chk("fill3_count", {61'h0, count}, 64'd3);
  endtask

  initial begin
    // reset state
    reset = 1'b1;
    repeat (3) step();
    chk("reset_addr", {32'h0, address_imem}, 64'h0);

    // streaming with out_ready held high
    reset = 1'b0; out_ready = 1'b1;
    repeat (12) step();

    // back-pressure until full, then drain
    reset = 1'b1; step();
    reset = 1'b0; out_ready = 1'b0;
    repeat (8) step();
    chk("full_count", {61'h0, count}, 64'd4);
    chk("full_addr", {32'h0, address_imem}, 64'd4);
    out_ready = 1'b1;
    repeat (10) step();

    // redirect with three entries queued and a response in flight
    reset = 1'b1; step();
    reset = 1'b0; out_ready = 1'b0;
    fill_to_three();
    redirect_valid = 1'b1; redirect_pc = 32'h40; step();
    redirect_valid = 1'b0; out_ready = 1'b1;
    step();
    chk("redir_r2_valid", {63'h0, out_valid}, 64'd0);
    step();
    chk("redir_r3_pc", {32'h0, out_pc}, 64'h40);
    chk("redir_r3_insn", {32'h0, out_insn}, 64'h140);
    repeat (3) step();

    // redirect to the top of the address space
    redirect_valid = 1'b1; redirect_pc = 32'hFFFF_FFFF; step();
    redirect_valid = 1'b0;
    step(); step();
    chk("w8_valid", {63'h0, v8}, 64'd1);
    chk("w8_pc0", {56'h0, pc8}, 64'hFF);
    chk("w8_pp0", {56'h0, pp8}, 64'h00);
    chk("w8_insn0", {32'h0, insn8}, 64'h1FF);
    step();
    chk("w8_pc1", {56'h0, pc8}, 64'h00);
    chk("w8_pp1", {56'h0, pp8}, 64'h01);
    chk("w8_insn1", {32'h0, insn8}, 64'h100);
    repeat (3) step();

    // redirect coincident with a handshake, then back-to-back redirects
    chk("hs_precond_valid", {63'h0, out_valid}, 64'd1);
    redirect_valid = 1'b1; redirect_pc = 32'h200; step();
    redirect_pc = 32'h300; step();
    redirect_valid = 1'b0;
    repeat (6) step();

    // reset while three entries queued and one in flight
    out_ready = 1'b0;
    fill_to_three();
    reset = 1'b1; step();
    reset = 1'b0; out_ready = 1'b1;
    repeat (6) step();

    // randomized traffic
    for (int i = 0; i < 600; i++) begin
      out_ready      = ($urandom_range(0, 9) < 7);
      redirect_valid = ($urandom_range(0, 19) == 0);
      redirect_pc    = ($urandom_range(0, 3) == 0) ? (32'hFFFF_FFFE + 32'($urandom_range(0, 1)))
                                                  : $urandom();
      reset          = ($urandom_range(0, 99) == 0);
      step();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
